// File: rtl/fft_mag_streamer_if.sv
// Valid/ready stream carrying one magnitude word per bin towards the spectrum consumer.
// The master drives the word and its bin number; the slave returns ready.
interface fft_mag_streamer_if #(
    parameter int DW = 16
) ();
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
    logic [3:0]    m_index;
    logic          m_last;

    modport master (
        output m_valid,
        output m_data,
        output m_index,
        output m_last,
        input  m_ready
    );

    modport slave (
        input  m_valid,
        input  m_data,
        input  m_index,
        input  m_last,
        output m_ready
    );
endinterface

// File: rtl/fft_mag_streamer.sv
// Snapshots the 16 complex FFT bins on capture and streams alpha-max-beta-min
// magnitudes in bin order, tracking overruns and completed frames.
module fft_mag_streamer #(
    parameter int NPT = 16,
    parameter int DW  = 16
) (
    input  logic                mclk,
    input  logic                puc_rst_n,
    input  logic                capture,
    input  logic [NPT*DW-1:0]   bin_re,
    input  logic [NPT*DW-1:0]   bin_im,
    input  logic                clr_overrun,
    output logic                busy,
    output logic                overrun,
    output logic [7:0]          frame_cnt,
    fft_mag_streamer_if.master  m_if
);

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_e;

    localparam logic [3:0] LAST_IDX = 4'(NPT - 1);

    state_e              state_q, state_d;
    logic [NPT*DW-1:0]   snap_re_q, snap_re_d;
    logic [NPT*DW-1:0]   snap_im_q, snap_im_d;
    logic                valid_q, valid_d;
    logic                last_q, last_d;
    logic [DW-1:0]       data_q, data_d;
    logic [3:0]          index_q, index_d;
    logic                overrun_q, overrun_d;
    logic [7:0]          frame_cnt_q, frame_cnt_d;
    logic                busy_q, busy_d;

    logic [3:0]          next_idx;
    logic [DW-1:0]       sel_re;
    logic [DW-1:0]       sel_im;
    logic [DW-1:0]       mag_first;
    logic [DW-1:0]       mag_next;
    logic                handshake;

    // The most negative value has no positive twin in DW bits, so it clamps.
    function automatic logic [DW-1:0] abs_sat(input logic [DW-1:0] v);
        logic [DW-1:0] r;
        if (v[DW-1]) begin
            if (v[DW-2:0] == '0) begin
                r = {1'b0, {(DW-1){1'b1}}};
            end else begin
                r = (~v) + DW'(1);
            end
        end else begin
            r = v;
        end
        return r;
    endfunction

    function automatic logic [DW-1:0] amax_bmin(input logic [DW-1:0] re,
                                                 input logic [DW-1:0] im);
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [DW-1:0] mx;
        logic [DW-1:0] mn;
        a = abs_sat(re);
        b = abs_sat(im);
        if (a >= b) begin
            mx = a;
            mn = b;
        end else begin
            mx = b;
            mn = a;
        end
        return mx + (mn >> 1);
    endfunction

    // Bin 0 is taken straight from the inputs since the snapshot is loaded on the same edge.
    always_comb begin
        next_idx  = index_q + 4'd1;
        sel_re    = snap_re_q[next_idx*DW +: DW];
        sel_im    = snap_im_q[next_idx*DW +: DW];
        mag_first = amax_bmin(bin_re[DW-1:0], bin_im[DW-1:0]);
        mag_next  = amax_bmin(sel_re, sel_im);
        handshake = valid_q & m_if.m_ready;
    end

    always_comb begin
        state_d     = state_q;
        snap_re_d   = snap_re_q;
        snap_im_d   = snap_im_q;
        valid_d     = valid_q;
        last_d      = last_q;
        data_d      = data_q;
        index_d     = index_q;
        frame_cnt_d = frame_cnt_q;
        overrun_d   = overrun_q;

        if (clr_overrun) begin
            overrun_d = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                if (capture) begin
                    snap_re_d = bin_re;
                    snap_im_d = bin_im;
                    data_d    = mag_first;
                    index_d   = 4'd0;
                    last_d    = 1'b0;
                    valid_d   = 1'b1;
                    state_d   = STREAM;
                end
            end
            STREAM: begin
                // Set after clear so a coincident clear cannot hide an overrun.
                if (capture) begin
                    overrun_d = 1'b1;
                end
                if (handshake) begin
                    if (index_q == LAST_IDX) begin
                        valid_d     = 1'b0;
                        last_d      = 1'b0;
                        frame_cnt_d = frame_cnt_q + 8'd1;
                        state_d     = IDLE;
                    end else begin
                        data_d  = mag_next;
                        index_d = next_idx;
                        last_d  = (next_idx == LAST_IDX);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d == STREAM);
    end

    always_ff @(posedge mclk) begin
        if (!puc_rst_n) begin
            state_q     <= IDLE;
            snap_re_q   <= '0;
            snap_im_q   <= '0;
            valid_q     <= 1'b0;
            last_q      <= 1'b0;
            data_q      <= '0;
            index_q     <= 4'd0;
            overrun_q   <= 1'b0;
            frame_cnt_q <= 8'd0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            snap_re_q   <= snap_re_d;
            snap_im_q   <= snap_im_d;
            valid_q     <= valid_d;
            last_q      <= last_d;
            data_q      <= data_d;
            index_q     <= index_d;
            overrun_q   <= overrun_d;
            frame_cnt_q <= frame_cnt_d;
            busy_q      <= busy_d;
        end
    end

    assign m_if.m_valid = valid_q;
    assign m_if.m_last  = last_q;
    assign m_if.m_data  = data_q;
    assign m_if.m_index = index_q;
    assign busy         = busy_q;
    assign overrun      = overrun_q;
    assign frame_cnt    = frame_cnt_q;

endmodule

// File: tb/tb_fft_mag_streamer.sv
// Directed bench for fft_mag_streamer: one task per scenario, each checking its own outputs.
module tb_fft_mag_streamer;

    localparam int NPT = 16;
    localparam int DW  = 16;

    logic               mclk = 1'b0;
    logic               puc_rst_n;
    logic               capture;
    logic [NPT*DW-1:0]  bin_re;
    logic [NPT*DW-1:0]  bin_im;
    logic               clr_overrun;
    logic               busy;
    logic               overrun;
    logic [7:0]         frame_cnt;

    int tests_run    = 0;
    int tests_failed = 0;
    int exp_frames   = 0;

    fft_mag_streamer_if #(.DW(DW)) m_if ();

    fft_mag_streamer #(.NPT(NPT), .DW(DW)) dut (
        .mclk        (mclk),
        .puc_rst_n   (puc_rst_n),
        .capture     (capture),
        .bin_re      (bin_re),
        .bin_im      (bin_im),
        .clr_overrun (clr_overrun),
        .busy        (busy),
        .overrun     (overrun),
        .frame_cnt   (frame_cnt),
        .m_if        (m_if)
    );

    always #5 mclk = ~mclk;

    task automatic tick();
        @(posedge mclk);
        #1;
    endtask

    task automatic set_bin(input int k, input int re, input int im);
        bin_re[k*DW +: DW] = 16'(re);
        bin_im[k*DW +: DW] = 16'(im);
    endtask

    // Reference magnitude computed with plain integers.
    function automatic int ref_mag(input int re, input int im);
        int a;
        int b;
        a = (re < 0) ? -re : re;
        b = (im < 0) ? -im : im;
        if (a > 32767) a = 32767;
        if (b > 32767) b = 32767;
        return (a > b) ? (a + b / 2) : (b + a / 2);
    endfunction

    task automatic test_reset();
        puc_rst_n     = 1'b0;
        capture       = 1'b0;
        clr_overrun   = 1'b0;
        m_if.m_ready  = 1'b0;
        bin_re        = '0;
        bin_im        = '0;
        tick();
        tick();
        tests_run++;
        if (m_if.m_valid !== 1'b0 || m_if.m_last !== 1'b0 || busy !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_ctrl: valid=%b last=%b busy=%b, required 0 0 0",
                     m_if.m_valid, m_if.m_last, busy);
        end
        tests_run++;
        if (m_if.m_data !== 16'd0 || m_if.m_index !== 4'd0) begin
            tests_failed++;
            $display("[TB] FAIL reset_data: data=%0d index=%0d, required 0 0",
                     m_if.m_data, m_if.m_index);
        end
        tests_run++;
        if (overrun !== 1'b0 || frame_cnt !== 8'd0) begin
            tests_failed++;
            $display("[TB] FAIL reset_status: overrun=%b frame_cnt=%0d, required 0 0",
                     overrun, frame_cnt);
        end
        puc_rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic_frame();
        logic [15:0] exp_mag [16];
        int busy_cycles;
        bin_re = '0;
        bin_im = '0;
        set_bin(0, 3, 4);
        set_bin(1, -5, 12);
        set_bin(2, 32767, 0);
        for (int k = 0; k < 16; k++) exp_mag[k] = 16'd0;
        exp_mag[0] = 16'd5;
        exp_mag[1] = 16'd14;
        exp_mag[2] = 16'd32767;
        busy_cycles  = 0;
        m_if.m_ready = 1'b1;
        capture      = 1'b1;
        tick();
        capture = 1'b0;
        for (int k = 0; k < 16; k++) begin
            tests_run++;
            if (m_if.m_valid !== 1'b1 || m_if.m_index !== 4'(k) ||
                m_if.m_data !== exp_mag[k] || m_if.m_last !== (k == 15)) begin
                tests_failed++;
                $display("[TB] FAIL basic_word%0d: valid=%b index=%0d data=%0d last=%b, required 1 %0d %0d %b",
                         k, m_if.m_valid, m_if.m_index, m_if.m_data, m_if.m_last,
                         k, exp_mag[k], (k == 15));
            end
            if (busy === 1'b1) busy_cycles++;
            tick();
        end
        exp_frames++;
        tests_run++;
        if (m_if.m_valid !== 1'b0 || m_if.m_last !== 1'b0 || busy !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL basic_end: valid=%b last=%b busy=%b, required 0 0 0",
                     m_if.m_valid, m_if.m_last, busy);
        end
        tests_run++;
        if (busy_cycles != 16) begin
            tests_failed++;
            $display("[TB] FAIL basic_busy_len: busy cycles=%0d, required 16", busy_cycles);
        end
        tests_run++;
        if (frame_cnt !== 8'(exp_frames)) begin
            tests_failed++;
            $display("[TB] FAIL basic_frame_cnt: got %0d, required %0d", frame_cnt, exp_frames);
        end
    endtask

    task automatic test_saturation();
        bin_re = '0;
        bin_im = '0;
        set_bin(7, -32768, -32768);
        set_bin(8, -32768, 0);
        m_if.m_ready = 1'b1;
        capture      = 1'b1;
        tick();
        capture = 1'b0;
        for (int k = 0; k < 16; k++) begin
            if (k == 7) begin
                tests_run++;
                if (m_if.m_index !== 4'd7 || m_if.m_data !== 16'hBFFE) begin
                    tests_failed++;
                    $display("[TB] FAIL sat_bin7: index=%0d data=%h, required 7 bffe",
                             m_if.m_index, m_if.m_data);
                end
            end
            if (k == 8) begin
                tests_run++;
                if (m_if.m_index !== 4'd8 || m_if.m_data !== 16'd32767) begin
                    tests_failed++;
                    $display("[TB] FAIL sat_bin8: index=%0d data=%0d, required 8 32767",
                             m_if.m_index, m_if.m_data);
                end
            end
            tick();
        end
        exp_frames++;
    endtask

    task automatic test_backpressure();
        int re_v [16];
        int im_v [16];
        int got;
        int cyc;
        logic stall;
        logic [15:0] prev_data;
        logic [3:0]  prev_idx;
        for (int k = 0; k < 16; k++) begin
            re_v[k] = k * 2000 - 15000;
            im_v[k] = 9000 - k * 1500;
            set_bin(k, re_v[k], im_v[k]);
        end
        got          = 0;
        cyc          = 0;
        stall        = 1'b0;
        prev_data    = '0;
        prev_idx     = '0;
        m_if.m_ready = 1'b0;
        capture      = 1'b1;
        tick();
        capture = 1'b0;
        while (got < 16 && cyc < 400) begin
            m_if.m_ready = ($urandom_range(0, 9) < 3);
            tests_run++;
            if (m_if.m_valid !== 1'b1) begin
                tests_failed++;
                $display("[TB] FAIL bp_valid_drop: valid=%b after %0d words, required 1",
                         m_if.m_valid, got);
            end
            if (stall) begin
                tests_run++;
                if (m_if.m_data !== prev_data || m_if.m_index !== prev_idx) begin
                    tests_failed++;
                    $display("[TB] FAIL bp_stall_hold: data=%0d index=%0d, required %0d %0d",
                             m_if.m_data, m_if.m_index, prev_data, prev_idx);
                end
            end
            if (m_if.m_valid === 1'b1 && m_if.m_ready === 1'b1) begin
                tests_run++;
                if (m_if.m_index !== 4'(got) || m_if.m_data !== 16'(ref_mag(re_v[got], im_v[got])) ||
                    m_if.m_last !== (got == 15)) begin
                    tests_failed++;
                    $display("[TB] FAIL bp_word%0d: index=%0d data=%0d last=%b, required %0d %0d %b",
                             got, m_if.m_index, m_if.m_data, m_if.m_last, got,
                             ref_mag(re_v[got], im_v[got]), (got == 15));
                end
                got++;
            end
            stall     = (m_if.m_valid === 1'b1) && (m_if.m_ready === 1'b0);
            prev_data = m_if.m_data;
            prev_idx  = m_if.m_index;
            tick();
            cyc++;
        end
        m_if.m_ready = 1'b1;
        exp_frames++;
        tests_run++;
        if (got != 16) begin
            tests_failed++;
            $display("[TB] FAIL bp_timeout: received %0d words, required 16", got);
        end
        tests_run++;
        if (m_if.m_valid !== 1'b0 || frame_cnt !== 8'(exp_frames)) begin
            tests_failed++;
            $display("[TB] FAIL bp_end: valid=%b frame_cnt=%0d, required 0 %0d",
                     m_if.m_valid, frame_cnt, exp_frames);
        end
    endtask

    task automatic test_overrun();
        int re_v [16];
        int im_v [16];
        for (int k = 0; k < 16; k++) begin
            re_v[k] = k * 1000 - 8000;
            im_v[k] = 3000 - k * 400;
            set_bin(k, re_v[k], im_v[k]);
        end
        m_if.m_ready = 1'b1;
        tests_run++;
        if (overrun !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL ovr_initial: overrun=%b, required 0", overrun);
        end
        capture = 1'b1;
        tick();
        capture = 1'b0;
        for (int k = 0; k < 16; k++) begin
            tests_run++;
            if (m_if.m_valid !== 1'b1 || m_if.m_index !== 4'(k) ||
                m_if.m_data !== 16'(ref_mag(re_v[k], im_v[k]))) begin
                tests_failed++;
                $display("[TB] FAIL ovr_word%0d: valid=%b index=%0d data=%0d, required 1 %0d %0d",
                         k, m_if.m_valid, m_if.m_index, m_if.m_data, k, ref_mag(re_v[k], im_v[k]));
            end
            capture     = (k == 5) || (k == 15);
            clr_overrun = (k == 8);
            if (k == 5) begin
                for (int j = 0; j < 16; j++) set_bin(j, 1234, -4321);
            end
            tick();
            capture     = 1'b0;
            clr_overrun = 1'b0;
            if (k == 5) begin
                tests_run++;
                if (overrun !== 1'b1) begin
                    tests_failed++;
                    $display("[TB] FAIL ovr_set_mid: overrun=%b, required 1", overrun);
                end
            end
            if (k == 8) begin
                tests_run++;
                if (overrun !== 1'b0) begin
                    tests_failed++;
                    $display("[TB] FAIL ovr_lone_clear_busy: overrun=%b, required 0", overrun);
                end
            end
        end
        exp_frames++;
        tests_run++;
        if (overrun !== 1'b1 || busy !== 1'b0 || m_if.m_valid !== 1'b0 || frame_cnt !== 8'(exp_frames)) begin
            tests_failed++;
            $display("[TB] FAIL ovr_final_hs: overrun=%b busy=%b valid=%b frame_cnt=%0d, required 1 0 0 %0d",
                     overrun, busy, m_if.m_valid, frame_cnt, exp_frames);
        end
        tick();
        tests_run++;
        if (busy !== 1'b0 || m_if.m_valid !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL ovr_ignored_capture: busy=%b valid=%b, required 0 0", busy, m_if.m_valid);
        end
        capture = 1'b1;
        tick();
        capture = 1'b0;
        for (int k = 0; k < 16; k++) begin
            capture     = (k == 3);
            clr_overrun = (k == 3);
            tick();
            capture     = 1'b0;
            clr_overrun = 1'b0;
            if (k == 3) begin
                tests_run++;
                if (overrun !== 1'b1) begin
                    tests_failed++;
                    $display("[TB] FAIL ovr_set_wins: overrun=%b, required 1", overrun);
                end
            end
        end
        exp_frames++;
        tests_run++;
        if (busy !== 1'b0 || frame_cnt !== 8'(exp_frames)) begin
            tests_failed++;
            $display("[TB] FAIL ovr_frame2_end: busy=%b frame_cnt=%0d, required 0 %0d",
                     busy, frame_cnt, exp_frames);
        end
        clr_overrun = 1'b1;
        tick();
        clr_overrun = 1'b0;
        tests_run++;
        if (overrun !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL ovr_lone_clear_idle: overrun=%b, required 0", overrun);
        end
    endtask

    task automatic test_reset_mid_frame();
        bin_re = '0;
        bin_im = '0;
        for (int k = 0; k < 16; k++) set_bin(k, 100 * k, -50 * k);
        m_if.m_ready = 1'b1;
        capture      = 1'b1;
        tick();
        capture = 1'b0;
        for (int k = 0; k < 9; k++) begin
            capture = (k == 4);
            tick();
            capture = 1'b0;
        end
        tests_run++;
        if (m_if.m_index !== 4'd9 || overrun !== 1'b1 || busy !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL rst_pre: index=%0d overrun=%b busy=%b, required 9 1 1",
                     m_if.m_index, overrun, busy);
        end
        puc_rst_n = 1'b0;
        tick();
        puc_rst_n  = 1'b1;
        exp_frames = 0;
        tests_run++;
        if (m_if.m_valid !== 1'b0 || busy !== 1'b0 || frame_cnt !== 8'd0 || overrun !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL rst_mid: valid=%b busy=%b frame_cnt=%0d overrun=%b, required 0 0 0 0",
                     m_if.m_valid, busy, frame_cnt, overrun);
        end
        set_bin(0, -6, 8);
        capture = 1'b1;
        tick();
        capture = 1'b0;
        tests_run++;
        if (m_if.m_valid !== 1'b1 || m_if.m_index !== 4'd0 || m_if.m_data !== 16'd11) begin
            tests_failed++;
            $display("[TB] FAIL rst_restart: valid=%b index=%0d data=%0d, required 1 0 11",
                     m_if.m_valid, m_if.m_index, m_if.m_data);
        end
        for (int k = 0; k < 16; k++) tick();
        exp_frames++;
        tests_run++;
        if (busy !== 1'b0 || frame_cnt !== 8'(exp_frames)) begin
            tests_failed++;
            $display("[TB] FAIL rst_restart_end: busy=%b frame_cnt=%0d, required 0 %0d",
                     busy, frame_cnt, exp_frames);
        end
    endtask

    task automatic test_wrap();
        logic seen_max;
        logic wrapped;
        logic timed_out;
        int   cyc;
        seen_max     = 1'b0;
        wrapped      = 1'b0;
        timed_out    = 1'b0;
        m_if.m_ready = 1'b1;
        for (int f = 0; f < 256 && !timed_out; f++) begin
            capture = 1'b1;
            tick();
            capture = 1'b0;
            cyc = 0;
            while (busy === 1'b1 && cyc < 40) begin
                tick();
                cyc++;
            end
            if (cyc >= 40) timed_out = 1'b1;
            exp_frames++;
            if (frame_cnt === 8'd255) seen_max = 1'b1;
            if (seen_max && frame_cnt === 8'd0) wrapped = 1'b1;
        end
        tests_run++;
        if (timed_out) begin
            tests_failed++;
            $display("[TB] FAIL wrap_timeout: busy stuck=%b, required 0 within 40 cycles", busy);
        end
        tests_run++;
        if (frame_cnt !== 8'(exp_frames)) begin
            tests_failed++;
            $display("[TB] FAIL wrap_count: frame_cnt=%0d, required %0d", frame_cnt, exp_frames % 256);
        end
        tests_run++;
        if (wrapped !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL wrap_zero: wrapped=%b, required 1", wrapped);
        end
        tests_run++;
        if (overrun !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL wrap_overrun: overrun=%b, required 0", overrun);
        end
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_saturation();
        test_backpressure();
        test_overrun();
        test_reset_mid_frame();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
